// File: rtl/usb_cmd_pkg.sv
// Shared constants and state encodings for the USB command decoder.
// Build option: USB_CMD_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
package usb_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h61;
    localparam logic [7:0] OP_READ  = 8'h62;
    localparam logic [7:0] OP_PING  = 8'h63;

    localparam logic [7:0] RSP_ACK       = 8'h06;
    localparam logic [7:0] RSP_NAK       = 8'h15;
    localparam logic [7:0] RSP_PING      = 8'hA5;
    localparam logic [7:0] RSP_CKSUM_ERR = 8'hEE;

`ifdef USB_CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef enum logic [1:0] {
        COLLECT,
        EXEC,
        RD_WAIT,
        RESPOND
    } state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT,
        TX_GAP
    } tx_state_e;

endpackage

// File: rtl/usb_cmd_tx_seq.sv
// Walks a one- or two-byte response through the transport's start/done
// handshake, leaving start low for exactly one cycle between bytes.
//
// state   | meaning
// TX_IDLE | nothing to send; waits for go
// TX_LOAD | byte and start presented to the transport
// TX_WAIT | start held until the transport reports the byte sent
// TX_GAP  | start low one cycle; load second byte or report completion
module usb_cmd_tx_seq
    import usb_cmd_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        go,
    input  logic        two,
    input  logic [15:0] rsp,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        cmpl
);

    tx_state_e   state_q, state_d;
    logic        start_q, start_d;
    logic [7:0]  data_q, data_d;
    logic        second_q, second_d;

    // State and output registers
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= TX_IDLE;
            start_q  <= 1'b0;
            data_q   <= 8'h00;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            data_q   <= data_d;
            second_q <= second_d;
        end
    end

    // Handshake sequencing; start is registered so it changes only on state entry
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        data_d   = data_q;
        second_d = second_q;
        cmpl     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (go) begin
                    state_d  = TX_LOAD;
                    start_d  = 1'b1;
                    data_d   = rsp[15:8];
                    second_d = 1'b0;
                end
            end
            TX_LOAD: state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_done) begin
                    state_d = TX_GAP;
                    start_d = 1'b0;
                end
            end
            TX_GAP: begin
                if (two && !second_q) begin
                    state_d  = TX_LOAD;
                    start_d  = 1'b1;
                    data_d   = rsp[7:0];
                    second_d = 1'b1;
                end else begin
                    state_d = TX_IDLE;
                    cmpl    = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_data  = data_q;
    assign tx_start = start_q;

endmodule

// File: rtl/usb_cmd_decoder.sv
// Command layer above the USB/JTAG byte link: frames bytes, runs register
// write/read/ping and hands the response to the transmit sequencer.
// Build option: USB_CMD_CHECKSUM_EN (5-byte frames, XOR checksum in the last byte).
//
// state   | meaning
// COLLECT | gathering frame bytes, inter-byte timeout armed once a frame starts
// EXEC    | one-cycle register strobe and response selection
// RD_WAIT | capture register read data into the response buffer
// RESPOND | transmit sequencer busy with the response
module usb_cmd_decoder
    import usb_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [7:0]  iRxD_DATA,
    input  logic        iRxD_Ready,
    output logic [7:0]  oTxD_DATA,
    output logic        oTxD_Start,
    input  logic        iTxD_Done,
    output logic [7:0]  oREG_ADDR,
    output logic [15:0] oREG_WDATA,
    output logic        oREG_WE,
    output logic        oREG_RE,
    input  logic [15:0] iREG_RDATA,
    output logic        oBusy,
    output logic [7:0]  oErr_Cnt
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      LAST_IDX = 3'(FRAME_LEN - 1);

    state_e                     state_q, state_d;
    logic [2:0]                 idx_q, idx_d;
    logic [FRAME_LEN-1:0][7:0]  frm_q, frm_d;
    logic [CNT_W-1:0]           tmo_q, tmo_d;
    logic [15:0]                resp_q, resp_d;
    logic                       two_q, two_d;
    logic                       tx_go_q, tx_go_d;
    logic [7:0]                 err_q, err_d;
    logic [8:0]                 err_sum;
    logic                       reg_we, reg_re, drop, frame_err, tmo_hit;
    logic                       cks_ok, tx_cmpl;

`ifdef USB_CMD_CHECKSUM_EN
    assign cks_ok = (frm_q[4] == (frm_q[0] ^ frm_q[1] ^ frm_q[2] ^ frm_q[3]));
`else
    assign cks_ok = 1'b1;
`endif

    // State, frame buffer, timeout counter and error counter registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= COLLECT;
            idx_q   <= 3'd0;
            frm_q   <= '0;
            tmo_q   <= TMO_LOAD;
            resp_q  <= 16'h0000;
            two_q   <= 1'b0;
            tx_go_q <= 1'b0;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            tmo_q   <= tmo_d;
            resp_q  <= resp_d;
            two_q   <= two_d;
            tx_go_q <= tx_go_d;
            err_q   <= err_d;
        end
    end

    // Frame collection, command execution and response selection
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frm_d     = frm_q;
        tmo_d     = tmo_q;
        resp_d    = resp_q;
        two_d     = two_q;
        tx_go_d   = 1'b0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        frame_err = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            COLLECT: begin
                // An arriving byte takes priority over an expiring timeout
                if (iRxD_Ready) begin
                    for (int i = 0; i < FRAME_LEN; i++) begin
                        if (idx_q == 3'(i)) frm_d[i] = iRxD_DATA;
                    end
                    tmo_d = TMO_LOAD;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 3'd0;
                        state_d = EXEC;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (idx_q != 3'd0) begin
                    if (tmo_q == '0) begin
                        tmo_hit = 1'b1;
                        idx_d   = 3'd0;
                        tmo_d   = TMO_LOAD;
                    end else begin
                        tmo_d = tmo_q - CNT_W'(1);
                    end
                end
            end
            EXEC: begin
                state_d = RESPOND;
                tx_go_d = 1'b1;
                two_d   = 1'b0;
                if (!cks_ok) begin
                    resp_d    = {RSP_CKSUM_ERR, 8'h00};
                    frame_err = 1'b1;
                end else begin
                    case (frm_q[0])
                        OP_WRITE: begin
                            reg_we = 1'b1;
                            resp_d = {RSP_ACK, 8'h00};
                        end
                        OP_READ: begin
                            reg_re  = 1'b1;
                            state_d = RD_WAIT;
                            tx_go_d = 1'b0;
                        end
                        OP_PING: resp_d = {RSP_PING, 8'h00};
                        default: begin
                            resp_d    = {RSP_NAK, 8'h00};
                            frame_err = 1'b1;
                        end
                    endcase
                end
            end
            RD_WAIT: begin
                resp_d  = iREG_RDATA;
                two_d   = 1'b1;
                tx_go_d = 1'b1;
                state_d = RESPOND;
            end
            RESPOND: begin
                if (tx_cmpl) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Dropped-frame counter; a stray byte and a frame error can land in the same cycle
    always_comb begin
        drop    = iRxD_Ready && (state_q != COLLECT);
        err_sum = {1'b0, err_q} + {8'd0, drop} + {8'd0, frame_err} + {8'd0, tmo_hit};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    usb_cmd_tx_seq u_tx_seq (
        .clk_sys  (iCLK),
        .rst_b    (iRST_n),
        .go       (tx_go_q),
        .two      (two_q),
        .rsp      (resp_q),
        .tx_done  (iTxD_Done),
        .tx_data  (oTxD_DATA),
        .tx_start (oTxD_Start),
        .cmpl     (tx_cmpl)
    );

    assign oREG_ADDR  = frm_q[1];
    assign oREG_WDATA = {frm_q[2], frm_q[3]};
    assign oREG_WE    = reg_we;
    assign oREG_RE    = reg_re;
    assign oBusy      = (state_q != COLLECT);
    assign oErr_Cnt   = err_q;

endmodule
